// File: rtl/uart_tx_arbiter.sv
// Arbitrates four byte sources onto one UART transmitter: round-robin grant, frame lock, start timeout.
// Define UART_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (requester 0 highest).
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int START_TMO = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ack,
    output logic [7:0]  dataout,
    output logic        wrsig,
    input  logic        tx_busy,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        err_tmo
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] LOAD       = 2'd1;
    localparam logic [1:0] WAIT_START = 2'd2;
    localparam logic [1:0] WAIT_DONE  = 2'd3;

    localparam int              CNT_W    = $clog2(START_TMO + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TMO - 1);

    logic [1:0]       state_reg;
    logic             lock_reg;
    logic [1:0]       lock_id_reg;
    logic [CNT_W-1:0] cnt_reg;
`ifndef UART_ARB_FIXED_PRIO_EN
    logic [1:0]       rr_ptr_reg;
`endif

    logic [7:0] req_byte [4];
    logic [1:0] cand [4];
    logic [3:0] cand_hit;
    logic [3:0] eligible;
    logic [1:0] winner;
    logic       found;

    // While a frame is open only its owner may compete.
    assign eligible = lock_reg ? (req_valid & (4'b0001 << lock_id_reg)) : req_valid;

    // cand[k] is the requester examined k-th in the search order.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_req
            assign req_byte[gi] = req_data[8*gi +: 8];
`ifdef UART_ARB_FIXED_PRIO_EN
            assign cand[gi] = 2'(gi);
`else
            assign cand[gi] = rr_ptr_reg + 2'(gi);
`endif
            assign cand_hit[gi] = eligible[cand[gi]];
        end
    endgenerate

    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner = cand[k];
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            dataout     <= 8'd0;
            wrsig       <= 1'b0;
            req_ack     <= 4'd0;
            grant_id    <= 2'd0;
            busy        <= 1'b0;
            err_tmo     <= 1'b0;
            lock_reg    <= 1'b0;
            lock_id_reg <= 2'd0;
            cnt_reg     <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
            rr_ptr_reg  <= 2'd0;
`endif
        end else begin
            wrsig   <= 1'b0;
            req_ack <= 4'd0;
            err_tmo <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!tx_busy && found) begin
                        grant_id  <= winner;
                        busy      <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    // A request withdrawn before the load is simply dropped.
                    if (req_valid[grant_id]) begin
                        dataout     <= req_byte[grant_id];
                        wrsig       <= 1'b1;
                        req_ack     <= 4'b0001 << grant_id;
                        lock_reg    <= ~req_last[grant_id];
                        lock_id_reg <= grant_id;
`ifndef UART_ARB_FIXED_PRIO_EN
                        rr_ptr_reg  <= grant_id + 2'd1;
`endif
                        cnt_reg     <= '0;
                        state_reg   <= WAIT_START;
                    end else begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                WAIT_START: begin
                    if (tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else if (cnt_reg >= CNT_LAST) begin
                        err_tmo   <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter START_TMO, default 16: cycles to wait for tx_busy to rise after a wrsig pulse.
REQ-002 Parameter (none other); requester count fixed at 4.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  4  per-requester byte-available flag, held until acked.
REQ-006 req_data  input  32  byte of requester i on bits [8i+7:8i].
REQ-007 req_last  input  4  byte of requester i ends its frame.
REQ-008 req_ack  output  4  one-cycle pulse, byte of requester i taken.
REQ-009 dataout  output  8  byte to transmitter, held between loads.
REQ-010 wrsig  output  1  one-cycle transmit-start pulse.
REQ-011 tx_busy  input  1  high while transmitter shifts a frame.
REQ-012 grant_id  output  2  index of requester currently owning transmitter.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 err_tmo  output  1  one-cycle pulse on start timeout.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, WAIT_START, WAIT_DONE; all outputs registered.
REQ-016 IDLE: if any eligible req_valid is high and tx_busy low at an edge, the block SHALL record the winner in grant_id and enter LOAD.
REQ-017 LOAD (one cycle): dataout = winner's byte, wrsig = 1, req_ack[winner] = 1; next state WAIT_START.
REQ-018 Latency: req_valid sampled at edge k in IDLE gives wrsig/ack high from edge k+1 to k+2.
REQ-019 WAIT_START: SHALL go to WAIT_DONE on tx_busy high; after START_TMO cycles without it, SHALL pulse err_tmo and go to IDLE.
REQ-020 WAIT_DONE: SHALL go to IDLE on the first edge with tx_busy low.
REQ-021 Arbitration SHALL be round-robin: the search starts at (last granted + 1) mod 4.
REQ-022 Frame lock: after acking a byte with req_last = 0, only that requester is eligible until one of its bytes with req_last = 1 is acked.
REQ-023 Locked requester deasserting req_valid SHALL NOT release the lock; the arbiter waits in IDLE.
REQ-024 Requests arriving in non-IDLE states SHALL be ignored until IDLE; req_valid dropped before ack SHALL cause no ack.
REQ-025 tx_busy high in IDLE SHALL block grants until it falls.
REQ-026 req_ack SHALL be one-hot or zero; wrsig and req_ack SHALL never be high for more than one cycle per byte.
REQ-027 Timeout counter SHALL saturate and SHALL not wrap.

Reset
REQ-028 On rst_n low, asynchronously: state IDLE, dataout 0, wrsig 0, req_ack 0, grant_id 0, busy 0, err_tmo 0, round-robin pointer 0, lock cleared, counter 0.
REQ-029 Reset mid-transfer SHALL abandon the byte with no further ack or wrsig; operation resumes from IDLE on the first edge after rst_n rises.

Configuration
REQ-030 Macro UART_ARB_FIXED_PRIO_EN defined: round-robin replaced by fixed priority, requester 0 highest, 3 lowest; frame lock still applies.
REQ-031 Macro undefined: round-robin per REQ-021.

Verification
REQ-032 Single request: req_valid=4'b0001, data 8'h55, last=1, tx_busy high 2 cycles after wrsig for 10 cycles -> one wrsig, dataout 8'h55, ack[0] once, grant_id 0.
REQ-033 Contention: all four valid continuously, last=1 -> grant order 0,1,2,3,0; with UART_ARB_FIXED_PRIO_EN -> grant 0 every time.
REQ-034 Frame lock: req1 sends 3 bytes (last on third) while req0 valid -> bytes 1,1,1 then 0; no req0 ack in between.
REQ-035 Timeout: tx_busy tied low, one request -> err_tmo pulse exactly 16 cycles after WAIT_START entry, back to IDLE, ack issued once.
REQ-036 Reset mid-WAIT_DONE: rst_n low 3 cycles -> all outputs 0 immediately, lock cleared, next grant starts from requester 0.
